// File: rtl/mat_rd_seq.sv
// Streams one DIM x DIM matrix out of a registered-read RAM, row- or column-major,
// through a 2-entry skid FIFO with valid/ready handshake on the output side.
module mat_rd_seq #(
    parameter int ADDR_LEN = 16,
    parameter int DATA_LEN = 8,
    parameter int DIM      = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] base_addr,
    input  logic                transpose,
    input  logic                abort,
    output logic [ADDR_LEN-1:0] rd_addr,
    input  logic [DATA_LEN-1:0] ram_q,
    output logic [DATA_LEN-1:0] out_data,
    output logic [7:0]          out_row,
    output logic [7:0]          out_col,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] LAST_IDX = 8'(DIM - 1);

    logic [1:0]          r_state;
    logic [ADDR_LEN-1:0] r_base;
    logic                r_tr;
    logic [7:0]          r_row;
    logic [7:0]          r_col;
    logic [ADDR_LEN-1:0] r_rd_addr;

    logic                r_inflight;
    logic [7:0]          r_inf_row;
    logic [7:0]          r_inf_col;
    logic                r_inf_last;

    logic [DATA_LEN-1:0] r_fifo_data [2];
    logic [7:0]          r_fifo_row  [2];
    logic [7:0]          r_fifo_col  [2];
    logic                r_fifo_last [2];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_count;

    logic                w_pop;
    logic                w_issue;
    logic                w_last_elem;
    logic                w_abort;
    logic [2:0]          w_occ_next;
    logic [ADDR_LEN-1:0] w_elem_addr;

    assign w_pop       = (r_count != 2'd0) && out_ready;
    assign w_last_elem = (r_row == LAST_IDX) && (r_col == LAST_IDX);
    assign w_abort     = abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
    // Occupancy after this cycle's push/pop; one slot must stay free for the read being issued.
    assign w_occ_next  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == S_RUN) && (w_occ_next <= 3'd1);
    assign w_elem_addr = r_base + ADDR_LEN'(r_row) * ADDR_LEN'(DIM) + ADDR_LEN'(r_col);

    assign rd_addr   = w_issue ? w_elem_addr : r_rd_addr;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_fifo_data[r_rptr];
    assign out_row   = r_fifo_row[r_rptr];
    assign out_col   = r_fifo_col[r_rptr];
    assign out_last  = r_fifo_last[r_rptr];
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_tr       <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_rd_addr  <= '0;
            r_inflight <= 1'b0;
            r_inf_row  <= '0;
            r_inf_col  <= '0;
            r_inf_last <= 1'b0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_row[i]  <= '0;
                r_fifo_col[i]  <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            if (w_issue) begin
                r_rd_addr <= w_elem_addr;
            end
            if (w_abort) begin
                r_state    <= S_IDLE;
                r_inflight <= 1'b0;
                r_wptr     <= 1'b0;
                r_rptr     <= 1'b0;
                r_count    <= 2'd0;
            end else begin
                // ram_q is only meaningful in the cycle right after an issue.
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inf_row  <= r_row;
                    r_inf_col  <= r_col;
                    r_inf_last <= w_last_elem;
                end
                if (r_inflight) begin
                    r_fifo_data[r_wptr] <= ram_q;
                    r_fifo_row[r_wptr]  <= r_inf_row;
                    r_fifo_col[r_wptr]  <= r_inf_col;
                    r_fifo_last[r_wptr] <= r_inf_last;
                    r_wptr              <= ~r_wptr;
                end
                if (w_pop) begin
                    r_rptr <= ~r_rptr;
                end
                r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};

                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_base  <= base_addr;
                            r_tr    <= transpose;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (w_issue) begin
                            if (w_last_elem) begin
                                r_state <= S_DRAIN;
                            end else if (r_tr) begin
                                if (r_row == LAST_IDX) begin
                                    r_row <= '0;
                                    r_col <= r_col + 8'd1;
                                end else begin
                                    r_row <= r_row + 8'd1;
                                end
                            end else begin
                                if (r_col == LAST_IDX) begin
                                    r_col <= '0;
                                    r_row <= r_row + 8'd1;
                                end else begin
                                    r_col <= r_col + 8'd1;
                                end
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (w_pop && r_fifo_last[r_rptr]) begin
                            r_state <= S_DONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mat_rd_seq.sv
// Directed bench for mat_rd_seq with DIM=4 and a RAM model returning the low address byte.
module tb_mat_rd_seq;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [15:0] base_addr;
    logic        transpose;
    logic        abort;
    logic [15:0] rd_addr;
    logic [7:0]  ram_q;
    logic [7:0]  out_data;
    logic [7:0]  out_row;
    logic [7:0]  out_col;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    mat_rd_seq #(.ADDR_LEN(16), .DATA_LEN(8), .DIM(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .base_addr(base_addr),
        .transpose(transpose), .abort(abort), .rd_addr(rd_addr), .ram_q(ram_q),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Registered-read RAM: RAM[a] = a[7:0]
    always @(posedge CLK) ram_q <= rd_addr[7:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_data"},    32'(out_data), 0);
        check({tag, "_row"},     32'(out_row), 0);
        check({tag, "_col"},     32'(out_col), 0);
        check({tag, "_last"},    32'(out_last), 0);
        check({tag, "_valid"},   32'(out_valid), 0);
        check({tag, "_busy"},    32'(busy), 0);
        check({tag, "_done"},    32'(done), 0);
    endtask

    function automatic int elem_r(input logic t, input int idx);
        return t ? (idx % 4) : (idx / 4);
    endfunction

    function automatic int elem_c(input logic t, input int idx);
        return t ? (idx / 4) : (idx % 4);
    endfunction

    function automatic logic [15:0] eaddr(input logic [15:0] b, input logic t, input int idx);
        return b + 16'(elem_r(t, idx) * 4 + elem_c(t, idx));
    endfunction

    task automatic run_mat(input logic [15:0] base, input logic tr, input bit rnd,
                           input bit restart, input int abort_at, input int rst_cyc);
        int n;
        int dones;
        bit fin;
        bit stall_q;
        bit abort_q;
        bit done_q;
        logic [7:0]  d_q;
        logic [15:0] ea;
        n = 0; dones = 0; fin = 0; stall_q = 0; abort_q = 0; done_q = 0; d_q = '0;
        @(negedge CLK);
        base_addr = base; transpose = tr; start = 1'b1; abort = 1'b1; out_ready = 1'b1;
        for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
            @(negedge CLK);
            start = restart && (cyc == 4);
            if (start) begin
                base_addr = base ^ 16'h0100;
                transpose = ~tr;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            abort = (abort_at >= 0) && (n == abort_at) && out_valid && !abort_q;
            RST_N = !(cyc == rst_cyc);
            #1;
            if (!RST_N) begin
                check_zero("rst_drain");
                fin = 1;
            end else if (abort_q) begin
                check("abort_busy",  32'(busy), 0);
                check("abort_valid", 32'(out_valid), 0);
                check("abort_done",  32'(done), 0);
                fin = 1;
            end else if (done_q) begin
                check("post_done_busy", 32'(busy), 0);
                check("post_done_done", 32'(done), 0);
                fin = 1;
            end else begin
                if (!rnd && cyc <= 16) begin
                    ea = eaddr(base, tr, cyc - 1);
                    check("rd_addr", 32'(rd_addr), 32'(ea));
                end
                if (!rnd && abort_at < 0)
                    check("valid_timing", 32'(out_valid), 32'(cyc >= 3 && cyc <= 18));
                if (stall_q) begin
                    check("stall_valid", 32'(out_valid), 1);
                    check("stall_data",  32'(out_data), 32'(d_q));
                end
                if (out_valid && out_ready) begin
                    ea = eaddr(base, tr, n);
                    check("out_data", 32'(out_data), 32'(ea[7:0]));
                    check("out_row",  32'(out_row),  32'(elem_r(tr, n)));
                    check("out_col",  32'(out_col),  32'(elem_c(tr, n)));
                    check("out_last", 32'(out_last), 32'(n == 15));
                    n++;
                end
                stall_q = out_valid && !out_ready;
                d_q = out_data;
                if (done) begin
                    dones++;
                    done_q = 1;
                    check("done_busy", 32'(busy), 1);
                    check("done_count", 32'(n), 16);
                    if (!rnd) check("done_cycle", 32'(cyc), 19);
                end
            end
            abort_q = abort;
        end
        start = 1'b0;
        abort = 1'b0;
        check("finished", 32'(fin), 1);
        if (abort_at < 0 && rst_cyc < 0) begin
            check("n_total", 32'(n), 16);
            check("dones", 32'(dones), 1);
        end
        if (abort_at >= 0) begin
            check("abort_n", 32'(n), 32'(abort_at + 1));
            check("abort_dones", 32'(dones), 0);
            repeat (6) begin
                @(negedge CLK);
                #1;
                check("abort_idle_done",  32'(done), 0);
                check("abort_idle_valid", 32'(out_valid), 0);
            end
        end
    endtask

    initial begin
        RST_N = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0;
        transpose = 1'b0; out_ready = 1'b0;
        #2;
        check_zero("reset");
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        abort = 1'b1;
        #1;
        check("idle_abort_busy", 32'(busy), 0);
        abort = 1'b0;

        run_mat(16'h0010, 1'b0, 1'b0, 1'b0, -1, -1);
        run_mat(16'h0010, 1'b1, 1'b0, 1'b0, -1, -1);
        run_mat(16'hFFFC, 1'b0, 1'b0, 1'b0, -1, -1);
        run_mat(16'h0020, 1'b0, 1'b1, 1'b0, -1, -1);
        run_mat(16'h0030, 1'b1, 1'b1, 1'b0, -1, -1);
        run_mat(16'h0040, 1'b0, 1'b0, 1'b1, -1, -1);
        run_mat(16'h0050, 1'b0, 1'b0, 1'b0, 5, -1);
        run_mat(16'h0060, 1'b0, 1'b0, 1'b0, -1, 17);

        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            #1;
            check("post_rst_valid", 32'(out_valid), 0);
            check("post_rst_busy",  32'(busy), 0);
        end
        run_mat(16'h0070, 1'b1, 1'b0, 1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
